cic_decimator_core: RTL
=======================

Name: cic_decimator_core

Overview:
- N-stage CIC decimator (Hogenauer, differential delay M=1) with a runtime-programmable decimation ratio.
- Accepts Q1.15 samples qualified by valid_in and produces full-precision ACC_WIDTH two's-complement results, one per dec_ratio accepted inputs.
- Sits directly upstream of the rounding/overflow stage in the CIC chain. Its data_out/valid_out drive that stage's data_in/valid_in with no glue logic.

Parameters:
- DATA_WIDTH, 16: input sample width, signed Q1.15.
- N_STAGES, 5: number of integrator stages and number of comb stages (legal range 1..8).
- DEC_MAX, 32: maximum decimation ratio, a power of two.
- ACC_WIDTH, 42: internal and output width. Must be >= DATA_WIDTH + N_STAGES*$clog2(DEC_MAX).

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all datapath state; has priority over valid_in.
- dec_ratio  in  $clog2(DEC_MAX)+1  decimation ratio R, legal 1..DEC_MAX. 0 is treated as 1; values above DEC_MAX are clamped to DEC_MAX.
- data_in  in  DATA_WIDTH  signed input sample.
- valid_in  in  1  data_in is accepted on every cycle this is high; there is no backpressure.
- data_out  out  ACC_WIDTH  signed decimated result.
- valid_out  out  1  single-cycle strobe qualifying data_out.
- busy  out  1  high while any comb pipeline stage holds a valid sample.

Behaviour:
- Reset (rst_n low, asynchronous) clears the following to 0: integrators, comb delay registers, comb pipeline registers and valid bits, phase counter, latched ratio, data_out, valid_out and busy. The first sample accepted after reset starts phase 0.
- clear (synchronous) has the same effect as reset, taking effect at the clock edge. A valid_in in the same cycle is dropped.
- Integrator section (updates only when valid_in is high):
  - int[0] <= int[0] + sext(data_in).
  - int[k] <= int[k] + int[k-1] for k = 1..N-1, using pre-edge register values.
  - All adds are modulo 2^ACC_WIDTH. Wrap-around is intentional and the comb section cancels it. No saturation anywhere in this block.
- Phase counter and ratio latch:
  - The ratio is latched from dec_ratio when phase == 0 and valid_in is high. Changing dec_ratio mid-frame has no effect until the next frame.
  - On each accepted sample: if phase == R_latched-1, phase <= 0 and a decimation tap fires; otherwise phase increments.
  - With R = 1, every accepted sample fires a tap.
- Decimation tap: in the cycle after the tap, comb stage 0 input = int[N-1], with its valid bit set.
- Comb section:
  - Stage k computes y = x - dly[k], then dly[k] <= x, only when that stage's valid bit is set.
  - Each stage registers y and the valid bit into the next stage, so one stage is traversed per cycle.
  - The pipeline accepts one tap per cycle with no bubbles (R = 1 with continuous valid_in).
- Output:
  - data_out / valid_out are registered from the last comb stage. data_out holds its last value while valid_out is low.
  - Latency: the tapping valid_in edge to valid_out high is N_STAGES+1 cycles (6 at defaults).
- Transfer function: H(z) = ((1 - z^-R)/(1 - z^-1))^N, plus a delay of N-1 input samples from the registered integrator chain.
  - DC gain is R^N.
  - The result is not scaled; gain compensation is done downstream.
- busy = OR of the comb valid bits.

Test Plan:
- Reset mid-frame: assert rst_n low asynchronously with phase = 2 and one comb stage valid -> all outputs are 0 immediately. The next valid_out occurs only after a fresh R samples plus 6 cycles.
- DC step, R=4, N=5: data_in = 0x0100 held with continuous valid_in -> output settles to 256*1024 = 0x40000 (data_out = 42'h0_0004_0000) and stays constant. valid_out pulses every 4th cycle.
- Impulse, R=1: one sample 0x7FFF, then zeros -> a single nonzero output 32767, 4 input samples later plus 6 cycles latency. All other outputs are 0.
- Negative full scale with wrap, R=32: data_in = 0x8000 continuous for 2000 samples -> integrators wrap, but steady output = -32768*32^5 = -2^40 exactly, with no glitch at the wrap points.
- Ratio change mid-frame: dec_ratio 8 -> 2 at phase 3 -> the current frame completes at 8 samples, then outputs come every 2 samples. dec_ratio = 0 behaves as 1.
- clear with valid_in high and the comb pipeline full -> no valid_out for the in-flight taps, busy drops to 0 the next cycle, and the dropped sample does not appear in any later output.

Source files
------------

// File: rtl/cic_decimator_core.sv
// rtl/cic_decimator_core.sv - N-stage CIC decimator (M=1) with runtime decimation ratio
// Modulo-2^ACC_WIDTH integrators feed a pipelined comb section, one comb stage per cycle.
module cic_decimator_core #(
  parameter int DATA_WIDTH = 16,
  parameter int N_STAGES   = 5,
  parameter int DEC_MAX    = 32,
  parameter int ACC_WIDTH  = 42
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic [$clog2(DEC_MAX):0]    dec_ratio,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        valid_in,
  output logic [ACC_WIDTH-1:0]        data_out,
  output logic                        valid_out,
  output logic                        busy
);

  localparam int PW = $clog2(DEC_MAX);
  localparam int RW = PW + 1;

  logic [ACC_WIDTH-1:0] integ [N_STAGES];
  logic [ACC_WIDTH-1:0] dly   [N_STAGES];
  logic [ACC_WIDTH-1:0] pipe  [1:N_STAGES];
  logic [ACC_WIDTH-1:0] cin   [N_STAGES];
  logic [N_STAGES:0]    vld;
  logic [PW-1:0]        phase;
  logic [RW-1:0]        r_lat;
  logic [RW-1:0]        r_req;
  logic [RW-1:0]        r_cur;
  logic                 tap;

  // At phase 0 the incoming ratio takes effect immediately so R=1 taps on the first sample.
  always_comb begin
    if (dec_ratio == '0) begin
      r_req = RW'(1);
    end else if (dec_ratio > RW'(DEC_MAX)) begin
      r_req = RW'(DEC_MAX);
    end else begin
      r_req = dec_ratio;
    end
    r_cur = (phase == '0) ? r_req : r_lat;
    tap   = valid_in && ({1'b0, phase} == (r_cur - RW'(1)));
  end

  always_comb begin
    cin[0] = integ[N_STAGES-1];
    for (int k = 1; k < N_STAGES; k++) begin
      cin[k] = pipe[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_STAGES; k++) begin
        integ[k]  <= '0;
        dly[k]    <= '0;
        pipe[k+1] <= '0;
      end
      vld       <= '0;
      phase     <= '0;
      r_lat     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < N_STAGES; k++) begin
        integ[k]  <= '0;
        dly[k]    <= '0;
        pipe[k+1] <= '0;
      end
      vld       <= '0;
      phase     <= '0;
      r_lat     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (valid_in) begin
        integ[0] <= integ[0] + {{(ACC_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        for (int k = 1; k < N_STAGES; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        if (phase == '0) begin
          r_lat <= r_req;
        end
        phase <= tap ? '0 : phase + PW'(1);
      end
      vld <= {vld[N_STAGES-1:0], tap};
      // Wrapped integrator values cancel exactly in the modulo differences below.
      for (int k = 0; k < N_STAGES; k++) begin
        if (vld[k]) begin
          dly[k]    <= cin[k];
          pipe[k+1] <= cin[k] - dly[k];
        end
      end
      valid_out <= vld[N_STAGES];
      if (vld[N_STAGES]) begin
        data_out <= pipe[N_STAGES];
      end
    end
  end

  assign busy = |vld;

endmodule
